// File: rtl/role_mem_rd_arb.sv
// role_mem_rd_arb: round-robin arbiter that lets two read requesters share one memory read port.
// A burst owns the shared port from its AR grant until the beat that carries m_rlast.
module role_mem_rd_arb #(
    parameter int ADDR_W = 36,
    parameter int DATA_W = 256
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,

    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,

    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic [1:0]        gnt,
    output logic              err_rlast
);

    // state   | meaning
    // IDLE    | no owner; arbitrate and accept one AR
    // ADDR    | latched AR presented on the shared port
    // DATA    | R beats routed to the owner until m_rlast
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [2:0]        arsize_q, arsize_d;
    logic [1:0]        arburst_q, arburst_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    logic any_valid;
    logic win;
    logic sel_rready;
    logic r_hs;
    logic beat_is_last;

    // ptr_q holds the last granted index, so a tie goes to the other requester.
    always_comb begin
        any_valid = s0_arvalid | s1_arvalid;
        if (s0_arvalid && s1_arvalid) begin
            win = ~ptr_q;
        end else begin
            win = s1_arvalid;
        end
        sel_rready   = gnt_q[1] ? s1_rready : s0_rready;
        r_hs         = (state_q == ST_DATA) & m_rvalid & sel_rready;
        beat_is_last = (beat_cnt_q == arlen_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b1;
            gnt_q      <= 2'b00;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        arburst_d  = arburst_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_ADDR;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    if (win) begin
                        araddr_d  = s1_araddr;
                        arlen_d   = s1_arlen;
                        arsize_d  = s1_arsize;
                        arburst_d = s1_arburst;
                    end else begin
                        araddr_d  = s0_araddr;
                        arlen_d   = s0_arlen;
                        arsize_d  = s0_arsize;
                        arburst_d = s0_arburst;
                    end
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    state_d    = ST_DATA;
                    beat_cnt_d = 8'd0;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // Flag rlast early or missing; the burst still ends only on m_rlast.
                    if (m_rlast != beat_is_last) begin
                        err_d = 1'b1;
                    end
                    if (m_rlast) begin
                        state_d = ST_IDLE;
                        ptr_d   = gnt_q[1];
                        gnt_d   = 2'b00;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Reset gates arready because the IDLE arbitration is otherwise purely combinational.
    always_comb begin
        s0_arready = aresetn & (state_q == ST_IDLE) & any_valid & ~win;
        s1_arready = aresetn & (state_q == ST_IDLE) & any_valid & win;
        m_arvalid  = (state_q == ST_ADDR);
        m_araddr   = araddr_q;
        m_arlen    = arlen_q;
        m_arsize   = arsize_q;
        m_arburst  = arburst_q;
        m_rready   = (state_q == ST_DATA) & sel_rready;
        s0_rvalid  = (state_q == ST_DATA) & m_rvalid & gnt_q[0];
        s1_rvalid  = (state_q == ST_DATA) & m_rvalid & gnt_q[1];
        s0_rdata   = m_rdata;
        s1_rdata   = m_rdata;
        s0_rresp   = m_rresp;
        s1_rresp   = m_rresp;
        s0_rlast   = m_rlast;
        s1_rlast   = m_rlast;
        gnt        = gnt_q;
        err_rlast  = err_q;
    end

endmodule

// File: tb/tb_role_mem_rd_arb.sv
// Bench for role_mem_rd_arb: directed and random bursts against a round-robin model,
// with the shared memory port played by the bench itself.
module tb_role_mem_rd_arb;
    localparam int AW = 36;
    localparam int DW = 256;
    localparam int BEAT_LIMIT = 400;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [AW-1:0] a_addr [2];
    logic [7:0]    a_len [2];
    logic [2:0]    a_size [2];
    logic [1:0]    a_burst [2];
    logic          a_valid [2];
    logic          r_ready [2];

    logic          s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic [1:0]    s0_rresp, s1_rresp;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid, m_rready, err_rlast;
    logic          m_arready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = '0;
    logic          m_rlast = 1'b0;
    logic          m_rvalid = 1'b0;
    logic [1:0]    gnt;

    role_mem_rd_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_araddr(a_addr[0]), .s0_arlen(a_len[0]), .s0_arsize(a_size[0]), .s0_arburst(a_burst[0]),
        .s0_arvalid(a_valid[0]), .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(r_ready[0]),
        .s1_araddr(a_addr[1]), .s1_arlen(a_len[1]), .s1_arsize(a_size[1]), .s1_arburst(a_burst[1]),
        .s1_arvalid(a_valid[1]), .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(r_ready[1]),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .gnt(gnt), .err_rlast(err_rlast)
    );

    int total = 0;
    int bad = 0;
    int last_gnt = 1;
    bit err_m = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            a_valid[i] = 1'b0;
            r_ready[i] = 1'b1;
        end
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
    endtask

    task automatic set_fields(input int n, input logic [AW-1:0] addr, input logic [7:0] len);
        a_addr[n]  = addr;
        a_len[n]   = len;
        a_size[n]  = 3'($urandom_range(7));
        a_burst[n] = 2'($urandom_range(3));
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        clear_inputs();
        a_valid[0] = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_arready0", s0_arready, 0);
        chk("rst_err", err_rlast, 0);
        chk("rst_araddr", m_araddr, 0);
        a_valid[0] = 1'b0;
        last_gnt = 1;
        err_m = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // One full burst: arbitration, ADDR stall, beats with random back-pressure.
    // off shifts the beat carrying m_rlast relative to arlen; abort_beat >= 0 resets mid-burst.
    task automatic burst(input bit v0, input bit v1, input int stall, input int off,
                         input int rr_pct, input int abort_beat);
        int w, rl, b, guard;
        bit rdy;
        logic [DW-1:0] d;
        logic [1:0] gexp;
        @(negedge aclk);
        a_valid[0] = v0;
        a_valid[1] = v1;
        if (v0 && v1) w = (last_gnt == 1) ? 0 : 1;
        else w = v1 ? 1 : 0;
        gexp = (w == 1) ? 2'b10 : 2'b01;
        #1;
        chk("arready0", s0_arready, (w == 0));
        chk("arready1", s1_arready, (w == 1));
        chk("gnt_idle", gnt, 0);

        @(negedge aclk);
        a_valid[0] = 1'b0;
        a_valid[1] = 1'b0;
        #1;
        chk("arvalid", m_arvalid, 1);
        chk("araddr", m_araddr, a_addr[w]);
        chk("arlen", m_arlen, a_len[w]);
        chk("arsize_burst", {m_arsize, m_arburst}, {a_size[w], a_burst[w]});
        chk("gnt_addr", gnt, gexp);

        for (int i = 0; i < stall; i++) begin
            @(negedge aclk);
            a_valid[0] = 1'b1;
            a_valid[1] = 1'b1;
            #1;
            chk("stall_arready", {s0_arready, s1_arready}, 0);
            chk("stall_arvalid", m_arvalid, 1);
            chk("stall_ar", {m_araddr, m_arlen, m_arsize, m_arburst},
                {a_addr[w], a_len[w], a_size[w], a_burst[w]});
        end

        @(negedge aclk);
        a_valid[0] = 1'b0;
        a_valid[1] = 1'b0;
        m_arready = 1'b1;
        #1;
        chk("arvalid_hs", m_arvalid, 1);
        @(negedge aclk);
        m_arready = 1'b0;
        #1;
        chk("arvalid_data", m_arvalid, 0);
        chk("gnt_data", gnt, gexp);

        rl = int'(a_len[w]) + off;
        b = 0;
        guard = 0;
        while (b <= rl && guard < BEAT_LIMIT) begin
            guard++;
            if (guard > 1) @(negedge aclk);
            if ($urandom_range(4) == 0) begin
                m_rvalid = 1'b0;
                r_ready[w] = 1'b1;
                #1;
                chk("gap_rvalid", {s1_rvalid, s0_rvalid}, 0);
                chk("gap_rready", m_rready, 1);
                @(negedge aclk);
            end
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m_rvalid = 1'b1;
            m_rdata = d;
            m_rresp = 2'($urandom_range(3));
            m_rlast = (b == rl);
            rdy = ($urandom_range(99) < rr_pct);
            r_ready[w] = rdy;
            r_ready[1 - w] = 1'($urandom_range(1));
            if (b == abort_beat) begin
                aresetn = 1'b0;
                a_valid[0] = 1'b1;
                a_valid[1] = 1'b1;
                #1;
                chk("abort_gnt", gnt, 0);
                chk("abort_arvalid", m_arvalid, 0);
                chk("abort_rready", m_rready, 0);
                chk("abort_rvalid", {s1_rvalid, s0_rvalid}, 0);
                chk("abort_arready", {s1_arready, s0_arready}, 0);
                chk("abort_err", err_rlast, 0);
                last_gnt = 1;
                err_m = 1'b0;
                clear_inputs();
                return;
            end
            #1;
            chk("rvalid_own", (w == 0) ? s0_rvalid : s1_rvalid, 1);
            chk("rvalid_other", (w == 0) ? s1_rvalid : s0_rvalid, 0);
            chk("rdata", {s1_rdata, s0_rdata}, {d, d});
            chk("rresp_rlast", {s0_rresp, s0_rlast, s1_rresp, s1_rlast},
                {m_rresp, (b == rl), m_rresp, (b == rl)});
            chk("m_rready", m_rready, rdy);
            if (rdy) b++;
        end
        chk("beat_budget", (guard < BEAT_LIMIT), 1);

        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        r_ready[0] = 1'b1;
        r_ready[1] = 1'b1;
        if (rl != int'(a_len[w])) err_m = 1'b1;
        last_gnt = w;
        #1;
        chk("gnt_end", gnt, 0);
        chk("rready_end", m_rready, 0);
        chk("err_rlast", err_rlast, err_m);
    endtask

    initial begin
        clear_inputs();
        set_fields(0, '0, 8'd0);
        set_fields(1, '0, 8'd0);
        do_reset();

        // s0 alone, 4-beat burst at a high address
        set_fields(0, 36'h1_0000_0000, 8'd3);
        burst(1, 0, 0, 0, 100, -1);

        // simultaneous requests alternate, starting from s0 after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_fields(0, AW'({$urandom, $urandom}), 8'($urandom_range(3)));
            set_fields(1, AW'({$urandom, $urandom}), 8'($urandom_range(3)));
            burst(1, 1, 0, 0, 100, -1);
            chk("alt_owner", last_gnt, i % 2);
        end

        // long AR stall and heavy read back-pressure
        set_fields(1, 36'h0_DEAD_BEEF, 8'd5);
        burst(0, 1, 10, 0, 30, -1);

        for (int i = 0; i < 30; i++) begin
            int v;
            v = $urandom_range(1, 3);
            set_fields(0, AW'({$urandom, $urandom}), 8'($urandom_range(7)));
            set_fields(1, AW'({$urandom, $urandom}), 8'($urandom_range(7)));
            burst(v[0], v[1], $urandom_range(3), 0, $urandom_range(50, 100), -1);
        end

        // early rlast, then missing rlast on a single-beat burst
        set_fields(0, 36'h0_0000_1000, 8'd3);
        burst(1, 0, 0, -2, 100, -1);
        set_fields(1, 36'h0_0000_2000, 8'd0);
        burst(0, 1, 0, 1, 100, -1);
        set_fields(0, 36'h0_0000_3000, 8'd1);
        burst(1, 0, 0, 0, 100, -1);

        // reset on beat 2 clears everything, then s0 wins the next tie
        set_fields(1, 36'h0_0000_4000, 8'd4);
        burst(0, 1, 0, 0, 100, 2);
        @(negedge aclk);
        aresetn = 1'b1;
        set_fields(0, 36'h0_0000_5000, 8'd1);
        set_fields(1, 36'h0_0000_6000, 8'd1);
        burst(1, 1, 0, 0, 100, -1);
        chk("post_reset_owner", last_gnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/role_mem_rd_arb.md
ROLE_MEM_RD_ARB -- requirements
Module: role_mem_rd_arb

Interface
REQ-001 Parameter ADDR_W, default 36, AR address width on all ports.
REQ-002 Parameter DATA_W, default 256, R data width on all ports.
REQ-003 aclk  in  1  sole clock; all state on its rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 sN_araddr  in  ADDR_W  requester N read address (N = 0, 1, one port set per requester).
REQ-006 sN_arlen  in  8  requester N burst length minus one.
REQ-007 sN_arsize  in  3  requester N beat size.
REQ-008 sN_arburst  in  2  requester N burst type.
REQ-009 sN_arvalid  in  1  requester N AR valid.
REQ-010 sN_arready  out  1  requester N AR accepted.
REQ-011 sN_rdata  out  DATA_W  read data to requester N.
REQ-012 sN_rresp  out  2  read response to requester N.
REQ-013 sN_rlast  out  1  last beat to requester N.
REQ-014 sN_rvalid  out  1  R valid to requester N.
REQ-015 sN_rready  in  1  requester N R ready.
REQ-016 m_araddr, m_arlen, m_arsize, m_arburst  out  ADDR_W/8/3/2  AR fields to shared memory port.
REQ-017 m_arvalid  out  1, m_arready  in  1  shared-port AR handshake.
REQ-018 m_rdata  in  DATA_W, m_rresp  in  2, m_rlast  in  1  shared-port R payload.
REQ-019 m_rvalid  in  1, m_rready  out  1  shared-port R handshake.
REQ-020 gnt  out  2  one-hot current owner; 2'b00 when idle.
REQ-021 err_rlast  out  1  sticky protocol error flag.

Function
REQ-022 FSM states IDLE, ADDR, DATA; exactly one read burst owns the shared port at a time.
REQ-023 IDLE: if any sN_arvalid, select winner combinationally, assert its sN_arready that cycle only, latch its AR fields and grant, go ADDR.
REQ-024 Arbitration round-robin: both valid -> requester not granted last; single valid -> that requester; last-grant pointer resets to 1 so s0 wins first tie.
REQ-025 ADDR: m_arvalid=1 with latched fields held stable; on m_arready go DATA; no sN_arready asserted outside IDLE.
REQ-026 DATA: sN_rvalid = m_rvalid for granted N only, other requester rvalid 0; m_rready = granted sN_rready; rdata/rresp/rlast broadcast to both.
REQ-027 DATA: on m_rvalid & m_rready & m_rlast go IDLE, pointer := granted requester, gnt := 00.
REQ-028 Latency: sN_arvalid sampled in IDLE at cycle t -> m_arvalid high from t+1; new grant earliest cycle after final beat handshake.
REQ-029 8-bit beat counter cleared entering DATA, incremented per R handshake.
REQ-030 err_rlast set when m_rlast on beat count != latched arlen, or beat count == arlen without m_rlast; burst still terminates only on m_rlast; flag cleared only by reset.
REQ-031 gnt one-hot in ADDR and DATA, 00 in IDLE.

Reset
REQ-032 aresetn low: state IDLE, m_arvalid=0, m_rready=0, sN_arready=0, sN_rvalid=0, gnt=00, err_rlast=0, pointer=1, counter=0, latched fields 0, immediately and asynchronously, including mid-burst.
REQ-033 After reset release, first cycle evaluates IDLE arbitration normally.

Verification
REQ-034 s0 only, araddr=0x1_0000_0000, arlen=3 -> s0_arready pulse 1 cycle, m_araddr matches next cycle, 4 beats reach s0, s1_rvalid stays 0, err_rlast=0.
REQ-035 s0 and s1 valid same cycle after reset, repeated -> grants s0, s1, s0, s1 alternating.
REQ-036 m_arready held low 10 cycles -> m_arvalid and m_ar fields stable throughout, no sN_arready pulses.
REQ-037 Granted requester drops rready mid-burst -> m_rready 0, beat not consumed, data stalls without loss.
REQ-038 arlen=3, m_rlast on beat 1 -> err_rlast=1 and sticky, FSM returns IDLE; also arlen=0 without rlast on beat 0 -> err_rlast=1.
REQ-039 aresetn low during DATA beat 2 -> all outputs at reset values same cycle; next request arbitrates from IDLE with s0 priority.
